// File: rtl/conv_window_gen.sv
// conv_window_gen: sliding KxK window generator over a raster AXI4-Stream frame.
// K-1 line buffers hold previous rows; a KxK register array forms the window.
// Valid (unpadded) windows leave through a single-register valid/ready stage.

module conv_line_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port; the asynchronous read below sees the pre-write contents this cycle
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

module conv_window_gen #(
  parameter int DATA_WIDTH  = 32,
  parameter int KERNEL_SIZE = 3,
  parameter int MAX_WIDTH   = 1024,
  parameter int DIM_BITS    = 10
) (
  input  logic                                        axi_clk,
  input  logic                                        axi_reset_n,
  input  logic                                        cfg_enable,
  input  logic [DIM_BITS-1:0]                         cfg_width,
  input  logic [DIM_BITS-1:0]                         cfg_height,
  output logic                                        cfg_err,
  input  logic                                        s_axis_valid,
  input  logic [DATA_WIDTH-1:0]                       s_axis_data,
  output logic                                        s_axis_ready,
  input  logic                                        s_axis_last,
  output logic                                        win_valid,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] win_data,
  input  logic                                        win_ready,
  output logic                                        win_last,
  output logic                                        err_last,
  output logic                                        frame_done
);
  localparam int K     = KERNEL_SIZE;
  localparam int LINES = K - 1;
  localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam logic [DIM_BITS-1:0] ONE = DIM_BITS'(1);
  localparam logic [DIM_BITS-1:0] KM1 = DIM_BITS'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [DIM_BITS-1:0] w_lat, h_lat, row, col;

  // win[r][c]: r=0 oldest line, c=0 leftmost column; packing puts element
  // r*K+c at bit offset (r*K+c)*DATA_WIDTH, matching the flat output layout
  logic [K-1:0][K-1:0][DATA_WIDTH-1:0] win;
  logic [K-1:0][DATA_WIDTH-1:0]        new_col;
  logic [LINES-1:0][DATA_WIDTH-1:0]    lb_rd, lb_wd;

  logic accept, at_last_col, at_last_row, last_pix, win_hit, cfg_ok;

  assign s_axis_ready = (state == RUN) && (!win_valid || win_ready);
  assign accept       = s_axis_valid && s_axis_ready;
  assign at_last_col  = (col == w_lat - ONE);
  assign at_last_row  = (row == h_lat - ONE);
  assign last_pix     = at_last_col && at_last_row;
  assign win_hit      = (row >= KM1) && (col >= KM1);
  assign cfg_ok       = (int'(cfg_width) >= K) && (int'(cfg_width) <= MAX_WIDTH) &&
                        (int'(cfg_height) >= K);
  assign frame_done   = (state == DONE) && win_valid && win_ready && win_last;
  assign win_data     = win;

  // Line buffers form a chain: each takes the next-newer line's old pixel at
  // this column, the newest takes the incoming pixel, so the oldest drops out
  genvar j;
  generate
    for (j = 0; j < LINES; j++) begin : g_lb
      if (j == LINES - 1) begin : g_top
        assign lb_wd[j] = s_axis_data;
      end else begin : g_mid
        assign lb_wd[j] = lb_rd[j+1];
      end
      assign new_col[j] = lb_rd[j];
      conv_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WIDTH),
        .AW         (AW)
      ) u_lb (
        .clk   (axi_clk),
        .we    (accept),
        .addr  (AW'(col)),
        .wdata (lb_wd[j]),
        .rdata (lb_rd[j])
      );
    end
  endgenerate

  assign new_col[K-1] = s_axis_data;

  // Frame sequencing: config latch, pixel position counters, sticky error flags
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state    <= IDLE;
      w_lat    <= '0;
      h_lat    <= '0;
      row      <= '0;
      col      <= '0;
      cfg_err  <= 1'b0;
      err_last <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_enable) begin
            if (cfg_ok) begin
              state    <= RUN;
              w_lat    <= cfg_width;
              h_lat    <= cfg_height;
              row      <= '0;
              col      <= '0;
              cfg_err  <= 1'b0;
              err_last <= 1'b0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            // tlast only flags a mismatch; the pixel count ends the frame
            if (s_axis_last != last_pix) err_last <= 1'b1;
            if (at_last_col) begin
              col <= '0;
              row <= row + ONE;
            end else begin
              col <= col + ONE;
            end
            if (last_pix) state <= DONE;
          end
        end
        DONE: begin
          if (frame_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Window array: shift one column left per accepted pixel, new column on the right
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      win <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win[r][c] <= win[r][c+1];
        win[r][K-1] <= new_col[r];
      end
    end
  end

  // Output valid/last: load on a window-completing pixel, drop on acceptance
  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end else if (accept) begin
      win_valid <= win_hit;
      win_last  <= last_pix;
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen, K=3 with 5x5 frames.
module tb_conv_window_gen;
  localparam int DW = 32;
  localparam int K  = 3;
  localparam int DB = 10;
  localparam int NW = K*K*DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [DB-1:0] cfg_width = '0, cfg_height = '0;
  logic          cfg_err;
  logic          s_axis_valid = 1'b0, s_axis_last = 1'b0, s_axis_ready;
  logic [DW-1:0] s_axis_data = '0;
  logic          win_valid, win_last, err_last, frame_done;
  logic          win_ready = 1'b1;
  logic [NW-1:0] win_data;

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_WIDTH(1024), .DIM_BITS(DB)) dut (
    .axi_clk(clk), .axi_reset_n(rst_n), .cfg_enable(cfg_enable), .cfg_width(cfg_width),
    .cfg_height(cfg_height), .cfg_err(cfg_err), .s_axis_valid(s_axis_valid),
    .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready), .s_axis_last(s_axis_last),
    .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready), .win_last(win_last),
    .err_last(err_last), .frame_done(frame_done));

  typedef struct { logic [NW-1:0] data; logic last; } exp_t;
  exp_t          sb[$];
  logic [NW-1:0] log_q[$];
  int checks = 0, passed = 0;
  int fd_cnt = 0, win_cnt = 0, fd_exp = 0;
  bit stall_arm = 1'b0;
  bit aborted = 1'b0;

  task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [NW-1:0] pack9(input int v[9]);
    logic [NW-1:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'(v[i]);
    return w;
  endfunction

  // window ending at (row,col) of a 5-wide frame whose pixels are base+row*5+col
  function automatic logic [NW-1:0] mkwin(input int base, input int row, input int col);
    logic [NW-1:0] w;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = DW'(base + (row-K+1+r)*5 + (col-K+1+c));
    return w;
  endfunction

  task automatic push_frame(input int base);
    exp_t e;
    for (int r = K-1; r < 5; r++)
      for (int c = K-1; c < 5; c++) begin
        e.data = mkwin(base, r, c);
        e.last = (r == 4) && (c == 4);
        sb.push_back(e);
      end
  endtask

  // Monitor: pop the scoreboard on every window handshake
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) fd_cnt++;
    if (win_valid && win_ready) begin
      if (sb.size() == 0) chk("unexpected_window", 1, 0);
      else begin
        e = sb.pop_front();
        chk("win_data", win_data, e.data);
        chk("win_last", NW'(win_last), NW'(e.last));
      end
      log_q.push_back(win_data);
      win_cnt++;
    end
  end

  // Downstream stall: hold win_ready low for 4 cycles while window 3 is presented
  initial begin
    int w3[9] = '{2,3,4,7,8,9,12,13,14};
    forever begin
      @(posedge clk); #1;
      if (stall_arm && win_valid && win_cnt == 2) begin
        stall_arm = 1'b0;
        win_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          chk("stall_ready", NW'(s_axis_ready), 0);
          chk("stall_valid", NW'(win_valid), 1);
          chk("stall_data", win_data, pack9(w3));
          @(posedge clk); #1;
        end
        win_ready = 1'b1;
      end
    end
  end

  task automatic send();
    int n = 0;
    bit ok;
    if (aborted) return;
    forever begin
      @(negedge clk);
      ok = s_axis_ready;
      @(posedge clk); #1;
      if (ok) return;
      if (++n > 300) begin
        chk("input_timeout", 1, 0);
        aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic run_frame(input int base, input int bad_idx, input int npix);
    cfg_width = 5; cfg_height = 5; cfg_enable = 1'b1;
    for (int i = 0; i < npix; i++) begin
      s_axis_valid = 1'b1;
      s_axis_data  = DW'(base + i);
      s_axis_last  = (i == 24) || (i == bad_idx);
      send();
      cfg_enable = 1'b0;
    end
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic wait_frame(input int nframes);
    int n = 0;
    fd_exp += nframes;
    while ((sb.size() != 0 || fd_cnt < fd_exp) && n < 300) begin
      @(negedge clk); n++;
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", NW'(sb.size()), 0);
    chk("frame_done_count", NW'(fd_cnt), NW'(fd_exp));
    @(posedge clk); #1;
  endtask

  initial begin
    int wfirst[9]  = '{0,1,2,5,6,7,10,11,12};
    int wlast[9]   = '{12,13,14,17,18,19,22,23,24};
    int w3[9]      = '{2,3,4,7,8,9,12,13,14};
    int wf2[9]     = '{100,101,102,105,106,107,110,111,112};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", NW'(win_valid), 0);
    chk("rst_ready", NW'(s_axis_ready), 0);
    chk("rst_flags", NW'({cfg_err, err_last, frame_done, win_last}), 0);
    chk("rst_data", win_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frame
    win_cnt = 0; log_q.delete();
    push_frame(0); run_frame(0, -1, 25); wait_frame(1);
    chk("t1_win_count", NW'(win_cnt), 9);
    chk("t1_first", log_q[0], pack9(wfirst));
    chk("t1_last", log_q[8], pack9(wlast));
    chk("t1_err_last", NW'(err_last), 0);

    // downstream stall after window 3
    win_cnt = 0; log_q.delete(); stall_arm = 1'b1;
    push_frame(0); run_frame(0, -1, 25); wait_frame(1);
    chk("t2_stall_seen", NW'(stall_arm), 0);
    chk("t2_win_count", NW'(win_cnt), 9);
    chk("t2_win3", log_q[2], pack9(w3));

    // illegal dimensions, then a legal frame
    cfg_width = 2; cfg_height = 5; cfg_enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_cfg_err", NW'(cfg_err), 1);
    chk("t3_idle_ready", NW'(s_axis_ready), 0);
    @(posedge clk); #1;
    win_cnt = 0;
    push_frame(0); run_frame(0, -1, 25); wait_frame(1);
    chk("t3_cfg_err_clr", NW'(cfg_err), 0);
    chk("t3_win_count", NW'(win_cnt), 9);

    // early tlast on pixel 19
    win_cnt = 0;
    push_frame(0); run_frame(0, 19, 25); wait_frame(1);
    chk("t4_err_last", NW'(err_last), 1);
    chk("t4_win_count", NW'(win_cnt), 9);

    // reset mid-frame after 12 pixels, then a clean frame
    run_frame(0, -1, 12);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ready", NW'(s_axis_ready), 0);
    chk("t5_async_valid", NW'(win_valid), 0);
    chk("t5_async_data", win_data, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    win_cnt = 0; log_q.delete();
    push_frame(0); run_frame(0, -1, 25); wait_frame(1);
    chk("t5_win_count", NW'(win_cnt), 9);
    chk("t5_first", log_q[0], pack9(wfirst));
    chk("t5_err_last", NW'(err_last), 0);

    // two back-to-back frames
    win_cnt = 0; log_q.delete();
    push_frame(0); push_frame(100);
    run_frame(0, -1, 25); run_frame(100, -1, 25); wait_frame(2);
    chk("t6_win_count", NW'(win_cnt), 18);
    chk("t6_f2_first", log_q[9], pack9(wf2));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream stage of Convolution_Controller.
- Accepts a raster-order AXI4-Stream pixel frame and buffers KERNEL_SIZE-1 full lines.
- Emits every valid (unpadded) KERNEL_SIZE x KERNEL_SIZE window as one flat word, in the same element layout that feeds the MULTIPLIER_INPUT bus of the matrix accelerator.
- Output uses a valid/ready handshake with window-level tlast.

Parameters:
- DATA_WIDTH, 32, pixel width in bits.
- KERNEL_SIZE, 3, window edge length; legal range 2..7.
- MAX_WIDTH, 1024, line-buffer depth; the maximum legal frame width.
- DIM_BITS, 10, width of the frame-dimension config ports.

Ports:
- axi_clk  in  1  clock; all logic is on the rising edge.
- axi_reset_n  in  1  reset, asynchronous, active-low.
- cfg_enable  in  1  level; starts a frame when the block is in IDLE.
- cfg_width  in  DIM_BITS  frame width in pixels; latched on leaving IDLE.
- cfg_height  in  DIM_BITS  frame height in lines; latched on leaving IDLE.
- cfg_err  out  1  sticky flag: illegal dimensions were requested.
- s_axis_valid  in  1  pixel valid.
- s_axis_data  in  DATA_WIDTH  pixel value.
- s_axis_ready  out  1  pixel accept.
- s_axis_last  in  1  end-of-frame marker on the input stream.
- win_valid  out  1  window valid.
- win_data  out  KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH  flat window; element r*K+c sits at bits [(r*K+c)*DATA_WIDTH +: DATA_WIDTH].
- win_ready  in  1  downstream accept.
- win_last  out  1  asserted with the final window of the frame.
- err_last  out  1  sticky flag: s_axis_last position mismatch.
- frame_done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset values: all outputs 0, state IDLE, all counters 0. Line-buffer RAM contents are not cleared.
- Window geometry:
  - r=0 is the oldest line and c=0 the leftmost column (K = KERNEL_SIZE).
  - Windows are produced only at pixel (row,col) with row>=K-1 and col>=K-1.
  - Count per frame = (W-K+1)*(H-K+1), emitted in raster order. No padding.
- State machine:
  - IDLE -> RUN when cfg_enable=1 and K<=cfg_width<=MAX_WIDTH and cfg_height>=K. On this transition, latch W and H and clear row, col, err_last and cfg_err.
  - When cfg_enable=1 with illegal dimensions: set cfg_err and stay in IDLE.
  - RUN -> DONE on acceptance of pixel (H-1,W-1).
  - DONE -> IDLE once the final window has been accepted (win_valid&win_ready with win_last); frame_done pulses that same cycle.
- Input handshake:
  - s_axis_ready = (state==RUN) && (!win_valid || win_ready).
  - A pixel is accepted on s_axis_valid&s_axis_ready.
  - Each accepted pixel:
    - writes line buffer at col and shifts the oldest line out;
    - shifts the KxK window register one column left, loading the new column from the line-buffer reads plus the incoming pixel;
    - advances col; col wraps to 0 and row increments at W-1.
- Output stage: single register, 1-cycle latency. win_valid rises on the cycle after the completing pixel is accepted.
- Output handshake: win_data and win_last are held stable while win_valid=1 and win_ready=0. win_valid clears on acceptance unless a new window loads in the same cycle.
- Simultaneous events: acceptance of a window and loading of the next window in the same cycle is legal, giving full throughput of one pixel per cycle.
- Line-buffer RAM: read-during-write at the same address returns the old data.
- tlast checking:
  - s_axis_last=1 on any accepted pixel other than (H-1,W-1) sets err_last.
  - s_axis_last=0 on pixel (H-1,W-1) also sets err_last.
  - Frame termination is governed only by the pixel count. A mid-frame tlast is ignored otherwise.
- Mid-frame changes: cfg_width, cfg_height and cfg_enable changes during RUN or DONE are ignored.
- Reset mid-operation returns all outputs and state to reset values immediately. The next frame must produce correct windows without a RAM flush.
- Arithmetic: no arithmetic is applied to pixel data; pixels pass through bit-exact. Counters are DIM_BITS wide.

Test Plan:
- K=3, W=H=5, pixel=col+5*row, win_ready=1 -> 9 windows. First window {0,1,2,5,6,7,10,11,12}, last window {12,13,14,17,18,19,22,23,24}. win_last only on the 9th window; frame_done pulses once; err_last=0.
- Same frame with win_ready held 0 for 4 cycles after the 3rd window -> s_axis_ready=0 during the stall, window 3 ({2,3,4,7,8,9,12,13,14}) stays stable, and the full window sequence is identical to the first test.
- cfg_width=2, cfg_enable=1 -> cfg_err=1, state stays IDLE, s_axis_ready=0. Then cfg_width=5 -> normal run, and cfg_err clears on entering RUN.
- s_axis_last=1 on pixel 19 of a 5x5 frame -> err_last=1, all 9 windows still produced, frame_done pulses after window 9.
- Assert axi_reset_n=0 after 12 pixels accepted -> all outputs 0 asynchronously. A new 5x5 frame after reset matches the first test exactly.
- Two back-to-back 5x5 frames, the second with pixel=100+index -> 18 windows total. First window of frame 2 is {100,101,102,105,106,107,110,111,112}, with no frame-1 data leaking in.
